sram_256x95_arbiter: RTL and testbench

Two-requester arbiter and initialiser for one 256x95 single-port synchronous SRAM macro (1-cycle read, per-bit write mask, chip enable). After reset it zero-fills the whole array. It then shares the single port between two valid/ready requesters with round-robin priority and returns read data to whichever requester issued the read. All SRAM-side signals are registered and always hold known values, so the macro's X-corruption check never fires.

---
 rtl/sram_256x95_arbiter_if.sv | 26 ++
 rtl/sram_256x95_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_256x95_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_256x95_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two valid/ready request ports
// plus the shared read-return path. The arbiter takes the slave modport,
// the requesters (or a testbench) take the master modport.
interface sram_256x95_arbiter_if #(
    parameter int BITS       = 95,
    parameter int ADDR_WIDTH = 8
);
    logic [1:0]                 req_v_i;
    logic [1:0]                 req_ready_o;
    logic [1:0]                 req_we_i;
    logic [1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [1:0][BITS-1:0]       req_wd_i;
    logic [1:0][BITS-1:0]       req_mask_i;
    logic [1:0]                 rdata_v_o;
    logic [BITS-1:0]            rdata_o;

    modport slave (
        input  req_v_i, req_we_i, req_addr_i, req_wd_i, req_mask_i,
        output req_ready_o, rdata_v_o, rdata_o
    );

    modport master (
        output req_v_i, req_we_i, req_addr_i, req_wd_i, req_mask_i,
        input  req_ready_o, rdata_v_o, rdata_o
    );
endinterface

// File: rtl/sram_256x95_arbiter.sv
// Two-requester round-robin arbiter and zero-fill initialiser for a
// 256x95 single-port synchronous SRAM. Every SRAM-side signal comes
// straight from a flop with a defined reset value, so the macro never
// sees X on its pins. Read data returns two cycles after accept, steered
// to the requester that issued the read by a small tag pipeline.
module sram_256x95_arbiter #(
    parameter int BITS       = 95,
    parameter int WORD_DEPTH = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    output logic                  init_done_o,
    sram_256x95_arbiter_if.slave  req,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [BITS-1:0]       ram_wd_o,
    output logic [BITS-1:0]       ram_mask_o,
    input  logic [BITS-1:0]       ram_rd_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ptr_q;
    logic                  both_v;
    logic                  gnt;
    logic                  gnt_v;
    logic                  tag_rd_q;
    logic                  tag_p_q;
    logic [1:0]            rdv_q;

    // State register: the block comes out of reset sweeping the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT once the last address is loaded; clear_i sends RUN back to INIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (cnt_q == LAST_ADDR) state_d = RUN;
            RUN:     if (clear_i) state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    // Outputs: grant choice, per-port ready and init_done; ready ignores the payload.
    always_comb begin
        init_done_o     = 1'b0;
        req.req_ready_o = 2'b00;
        gnt_v           = 1'b0;
        both_v          = &req.req_v_i;
        gnt             = both_v ? ptr_q : req.req_v_i[1];
        if (state_q == RUN) begin
            init_done_o = 1'b1;
            if (!clear_i && (|req.req_v_i)) begin
                gnt_v           = 1'b1;
                req.req_ready_o = gnt ? 2'b10 : 2'b01;
            end
        end
    end

    // Sweep counter: advances every INIT cycle (wrapping to 0), restarts on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (clear_i) begin
            cnt_q <= '0;
        end
    end

    // Round-robin pointer: moves away from the winner only when both ports competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (gnt_v && both_v) begin
            ptr_q <= ~gnt;
        end
    end

    // SRAM pin registers: zero-fill writes in INIT, the accepted op in RUN, else idle with held payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ce_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_wd_o   <= '0;
            ram_mask_o <= '0;
        end else if (state_q == INIT) begin
            ram_ce_o   <= 1'b1;
            ram_we_o   <= 1'b1;
            ram_addr_o <= cnt_q;
            ram_wd_o   <= '0;
            ram_mask_o <= '1;
        end else if (gnt_v) begin
            ram_ce_o   <= 1'b1;
            ram_we_o   <= req.req_we_i[gnt];
            ram_addr_o <= req.req_addr_i[gnt];
            ram_wd_o   <= req.req_wd_i[gnt];
            ram_mask_o <= req.req_mask_i[gnt];
        end else begin
            ram_ce_o   <= 1'b0;
            ram_we_o   <= 1'b0;
        end
    end

    // Tag register: remembers whether the op now on the pins is a read and who issued it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd_q <= 1'b0;
            tag_p_q  <= 1'b0;
        end else begin
            tag_rd_q <= gnt_v && !req.req_we_i[gnt];
            tag_p_q  <= gnt;
        end
    end

    // Response valid: one-cycle pulse to the owning port while the macro drives the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdv_q <= 2'b00;
        end else begin
            rdv_q <= {tag_rd_q && tag_p_q, tag_rd_q && !tag_p_q};
        end
    end

    assign req.rdata_v_o = rdv_q;
    assign req.rdata_o   = ram_rd_i;

endmodule

// File: tb/tb_sram_256x95_arbiter.sv
// Self-checking bench for sram_256x95_arbiter: a behavioural SRAM macro,
// the reset/zero-fill sweep, a table of per-cycle request vectors with
// hand-computed ready/response values, and hand-written clear and reset
// sequences.
module tb_sram_256x95_arbiter;

    localparam logic [94:0] ALL1   = {95{1'b1}};
    localparam logic [94:0] LOW8   = 95'hFF;
    localparam logic [94:0] MASKED = {{87{1'b1}}, 8'h00};
    localparam logic [94:0] D2A5   = 95'h2A5;

    logic        clk;
    logic        rst_n;
    logic        clear_i;
    logic        init_done_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [7:0]  ram_addr_o;
    logic [94:0] ram_wd_o;
    logic [94:0] ram_mask_o;
    logic [94:0] ram_rd_i;

    int n_checks;
    int n_pass;

    sram_256x95_arbiter_if #(.BITS(95), .ADDR_WIDTH(8)) bus ();

    sram_256x95_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .init_done_o(init_done_o),
        .req        (bus),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wd_o   (ram_wd_o),
        .ram_mask_o (ram_mask_o),
        .ram_rd_i   (ram_rd_i)
    );

    // Behavioural macro: 1-cycle read, per-bit write mask, starts full of garbage.
    logic [94:0] mem [256];

    initial begin
        ram_rd_i = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom(), $urandom(), $urandom()};
        end
    end

    always @(posedge clk) begin
        if (ram_ce_o) begin
            if (ram_we_o) begin
                mem[ram_addr_o] <= (ram_wd_o & ram_mask_o) | (mem[ram_addr_o] & ~ram_mask_o);
            end else begin
                ram_rd_i <= mem[ram_addr_o];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        string       name;
        logic [1:0]  v;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [94:0] wd0;
        logic [94:0] m0;
        logic [7:0]  a1;
        logic [94:0] wd1;
        logic [94:0] m1;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rdv;
        logic [94:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [1:0] v, input logic [1:0] we,
                                input logic [7:0] a0, input logic [94:0] wd0, input logic [94:0] m0,
                                input logic [7:0] a1, input logic [94:0] wd1, input logic [94:0] m1,
                                input logic [1:0] er, input logic [1:0] ed, input logic [94:0] erd);
        vec_t t;
        t.name = name; t.v = v; t.we = we;
        t.a0 = a0; t.wd0 = wd0; t.m0 = m0;
        t.a1 = a1; t.wd1 = wd1; t.m1 = m1;
        t.exp_ready = er; t.exp_rdv = ed; t.exp_rd = erd;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        clear_i           = 1'b0;
        bus.req_v_i       = t.v;
        bus.req_we_i      = t.we;
        bus.req_addr_i[0] = t.a0;
        bus.req_wd_i[0]   = t.wd0;
        bus.req_mask_i[0] = t.m0;
        bus.req_addr_i[1] = t.a1;
        bus.req_wd_i[1]   = t.wd1;
        bus.req_mask_i[1] = t.m1;
    endtask

    task automatic idleInputs();
        bus.req_v_i    = 2'b00;
        bus.req_we_i   = 2'b00;
        bus.req_addr_i = '0;
        bus.req_wd_i   = '0;
        bus.req_mask_i = '0;
    endtask

    // Called just after an edge; checks the sweep write on the pins for cycles 1..ncycles.
    task automatic sweepCheck(input string tag, input int ncycles);
        for (int k = 1; k <= ncycles; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s.cyc%0d", tag, k),
                        {ram_ce_o, ram_we_o, ram_addr_o, (ram_wd_o == '0), (ram_mask_o == ALL1),
                         bus.rdata_v_o, init_done_o},
                        {1'b1, 1'b1, 8'(k - 1), 1'b1, 1'b1, 2'b00, (k == 256)});
        end
    endtask

    // One table row per cycle: drive after the edge, check at the falling edge.
    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput({vecs[i].name, ".ready"}, {init_done_o, bus.req_ready_o}, {1'b1, vecs[i].exp_ready});
            checkOutput({vecs[i].name, ".rdv"}, bus.rdata_v_o, vecs[i].exp_rdv);
            if (vecs[i].exp_rdv != 2'b00) begin
                checkOutput({vecs[i].name, ".rdata"}, bus.rdata_o, vecs[i].exp_rd);
            end
            @(posedge clk);
            #1;
        end
        idleInputs();
    endtask

    int t1_end;
    int t2_end;

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Table 1: after the first sweep, memory is all zero and the pointer is 0.
        vecs.push_back(mk("rd80_p0", 2'b01, 2'b00, 8'h80, '0, '0, 8'h00, '0, '0, 2'b01, 2'b00, '0));
        vecs.push_back(mk("wr10_p0", 2'b01, 2'b01, 8'h10, D2A5, ALL1, 8'h00, '0, '0, 2'b01, 2'b00, '0));
        vecs.push_back(mk("rd10_p0", 2'b01, 2'b00, 8'h10, '0, '0, 8'h00, '0, '0, 2'b01, 2'b01, '0));
        vecs.push_back(mk("wr5_p0", 2'b01, 2'b01, 8'h05, ALL1, ALL1, 8'h00, '0, '0, 2'b01, 2'b00, '0));
        vecs.push_back(mk("wr5m_p1", 2'b10, 2'b10, 8'h00, '0, '0, 8'h05, '0, LOW8, 2'b10, 2'b01, D2A5));
        vecs.push_back(mk("rd5_p1", 2'b10, 2'b00, 8'h00, '0, '0, 8'h05, '0, '0, 2'b10, 2'b00, '0));
        vecs.push_back(mk("idle0", 2'b00, 2'b00, 8'h00, '0, '0, 8'h00, '0, '0, 2'b00, 2'b00, '0));
        vecs.push_back(mk("idle1", 2'b00, 2'b00, 8'h00, '0, '0, 8'h00, '0, '0, 2'b00, 2'b10, MASKED));
        vecs.push_back(mk("both0", 2'b11, 2'b00, 8'h10, '0, '0, 8'h05, '0, '0, 2'b01, 2'b00, '0));
        vecs.push_back(mk("both1", 2'b11, 2'b00, 8'h10, '0, '0, 8'h05, '0, '0, 2'b10, 2'b00, '0));
        vecs.push_back(mk("both2", 2'b11, 2'b00, 8'h10, '0, '0, 8'h05, '0, '0, 2'b01, 2'b01, D2A5));
        vecs.push_back(mk("both3", 2'b11, 2'b00, 8'h10, '0, '0, 8'h05, '0, '0, 2'b10, 2'b10, MASKED));
        vecs.push_back(mk("drain0", 2'b00, 2'b00, 8'h00, '0, '0, 8'h00, '0, '0, 2'b00, 2'b01, D2A5));
        vecs.push_back(mk("drain1", 2'b00, 2'b00, 8'h00, '0, '0, 8'h00, '0, '0, 2'b00, 2'b10, MASKED));
        t1_end = vecs.size() - 1;
        // Table 2: after clear and a fresh sweep, earlier data reads back as zero (pointer is 0).
        vecs.push_back(mk("post_b0", 2'b11, 2'b00, 8'h10, '0, '0, 8'h05, '0, '0, 2'b01, 2'b00, '0));
        vecs.push_back(mk("post_b1", 2'b10, 2'b00, 8'h10, '0, '0, 8'h05, '0, '0, 2'b10, 2'b00, '0));
        vecs.push_back(mk("post_d0", 2'b00, 2'b00, 8'h00, '0, '0, 8'h00, '0, '0, 2'b00, 2'b01, '0));
        vecs.push_back(mk("post_d1", 2'b00, 2'b00, 8'h00, '0, '0, 8'h00, '0, '0, 2'b00, 2'b10, '0));
        t2_end = vecs.size() - 1;

        // Reset state, with both requesters asserting valid.
        rst_n   = 1'b0;
        clear_i = 1'b0;
        idleInputs();
        bus.req_v_i = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.pins", {ram_ce_o, ram_we_o, ram_addr_o, ram_wd_o, ram_mask_o}, '0);
        checkOutput("reset.ctrl", {init_done_o, bus.req_ready_o, bus.rdata_v_o}, 5'b0);

        // Release and watch the full zero-fill sweep.
        @(negedge clk);
        rst_n = 1'b1;
        idleInputs();
        sweepCheck("sweep1", 256);

        runVectors(0, t1_end);

        // clear_i the cycle after a read accept: the read still returns, then a new sweep.
        bus.req_v_i       = 2'b01;
        bus.req_we_i      = 2'b00;
        bus.req_addr_i[0] = 8'h10;
        @(negedge clk);
        checkOutput("clr.accept", bus.req_ready_o, 2'b01);
        @(posedge clk);
        #1;
        clear_i = 1'b1;
        @(negedge clk);
        checkOutput("clr.no_grant", {init_done_o, bus.req_ready_o}, 3'b100);
        checkOutput("clr.rd_pins", {ram_ce_o, ram_we_o, ram_addr_o}, {1'b1, 1'b0, 8'h10});
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        idleInputs();
        checkOutput("clr.rdv", {init_done_o, bus.rdata_v_o, ram_ce_o}, {1'b0, 2'b01, 1'b0});
        checkOutput("clr.rdata", bus.rdata_o, D2A5);
        sweepCheck("sweep2", 256);

        runVectors(t1_end + 1, t2_end);

        // Reset with a read in flight: everything clears at once and no response follows.
        bus.req_v_i       = 2'b01;
        bus.req_we_i      = 2'b00;
        bus.req_addr_i[0] = 8'h80;
        @(negedge clk);
        checkOutput("rst_rd.accept", bus.req_ready_o, 2'b01);
        @(posedge clk);
        #1;
        idleInputs();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rd.pins", {ram_ce_o, ram_we_o, ram_addr_o, ram_mask_o}, '0);
        checkOutput("rst_rd.ctrl", {init_done_o, bus.rdata_v_o}, 3'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sweepCheck("sweep3", 101);

        // Reset in the middle of the sweep (address 100 on the pins): restart from address 0.
        checkOutput("mid.addr_before", ram_addr_o, 8'd100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid.pins", {ram_ce_o, ram_we_o, ram_addr_o, ram_mask_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sweepCheck("sweep4", 256);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
